serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 121 ++++++++++++
 tb/tb_serial_subtractor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - borrow-in subtractor, LSB first, one bit per clock
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_borrow,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic bit_diff;
    logic br_next;
    logic load;

    assign bit_diff = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    // DONE also accepts a start so a held i_start sustains one operation per WIDTH+1 cycles.
    assign load = i_start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            SUB: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                res_d = {bit_diff, res_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // br_q is the borrow into the MSB on this edge.
                    diff_d   = {bit_diff, res_q[WIDTH-1:1]};
                    borrow_d = br_next;
                    ovf_d    = br_q ^ br_next;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            a_d     = i_a;
            b_d     = i_b;
            br_d    = i_borrow;
            res_d   = '0;
            cnt_d   = '0;
            state_d = SUB;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_busy   = (state_q == SUB);
    assign o_done   = (state_q == DONE);
    assign o_diff   = diff_q;
    assign o_borrow = borrow_q;
    assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed-vector bench for serial_subtractor (WIDTH=4)
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks;
    int errors;

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_borrow(bin),
        .o_busy  (busy),
        .o_done  (done),
        .o_diff  (diff),
        .o_borrow(bout),
        .o_ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one operation and waits for o_done; lat counts edges from the accepting edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                          output int lat);
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout a=%0d b=%0d bin=%0d: no done within %0d edges", ta, tb_, tbin, lat);
        end
    endtask

    task automatic check_res(input string name, input logic [W-1:0] ed, input logic eb, input logic eo);
        checks++;
        if (diff !== ed || bout !== eb || ovf !== eo) begin
            errors++;
            $display("FAIL %s: got diff=%b borrow=%b ovf=%b, expected diff=%b borrow=%b ovf=%b",
                     name, diff, bout, ovf, ed, eb, eo);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b diff=%b borrow=%b ovf=%b, expected all 0",
                     busy, done, diff, bout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        run_op(4'd9, 4'd3, 1'b0, lat);
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL done_latency: got %0d edges, expected %0d", lat, W);
        end
        // 9 - 3 as signed is -7 - 3 = -10, outside [-8,7].
        check_res("9-3", 4'b0110, 1'b0, 1'b1);
        run_op(4'd3, 4'd9, 1'b0, lat);
        check_res("3-9", 4'b1010, 1'b1, 1'b1);
        run_op(4'd0, 4'd0, 1'b1, lat);
        check_res("0-0-1", 4'b1111, 1'b1, 1'b0);
        run_op(4'd8, 4'd1, 1'b0, lat);
        check_res("8-1", 4'b0111, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: done=%b one cycle after pulse, expected 0", done);
        end
    endtask

    task automatic test_ignore_start;
        int ndone;
        @(negedge clk);
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; a = 4'd1; b = 4'd1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept: busy=%b expected 1", busy);
        end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) begin
                start = 1'b1; a = 4'd15; bin = 1'b1;
            end else if (i == 2) begin
                start = 1'b0; b = 4'd7;
            end
            if (i == 2)
                check_res("hold_prev", 4'b0111, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                check_res("ignore_9-3", 4'b0110, 1'b0, 1'b1);
            end
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL single_done: got %0d done pulses, expected 1", ndone);
        end
    endtask

    task automatic test_async_reset;
        int lat;
        @(negedge clk);
        a = 4'd12; b = 4'd1; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b diff=%b borrow=%b ovf=%b, expected all 0",
                     busy, done, diff, bout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0) begin
            errors++;
            $display("FAIL no_partial_after_reset: busy=%b done=%b diff=%b, expected 0 0 0000",
                     busy, done, diff);
        end
        run_op(4'd5, 4'd2, 1'b0, lat);
        check_res("5-2_after_reset", 4'b0011, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int done_cyc[$];
        @(negedge clk);
        a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_cyc.push_back(cyc);
                check_res("b2b_7-2", 4'b0101, 1'b0, 1'b0);
            end
            if (cyc == 15) start = 1'b0;
        end
        checks++;
        if (done_cyc.size() !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses, expected 3", done_cyc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (done_cyc[k] !== 5 + 5 * k) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: done at cycle %0d, expected %0d",
                             k, done_cyc[k], 5 + 5 * k);
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_sweep;
        int lat;
        int sa, sb, sr, ur;
        logic [W-1:0] ed;
        logic eb, eo;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    ur = x - y - c;
                    sa = (x >= 8) ? x - 16 : x;
                    sb = (y >= 8) ? y - 16 : y;
                    sr = sa - sb - c;
                    ed = W'(ur & 15);
                    eb = (ur < 0);
                    eo = (sr < -8) || (sr > 7);
                    run_op(W'(x), W'(y), c[0], lat);
                    checks++;
                    if (diff !== ed || bout !== eb || ovf !== eo) begin
                        errors++;
                        $display("FAIL sweep %0d-%0d-%0d: got diff=%b borrow=%b ovf=%b, expected diff=%b borrow=%b ovf=%b",
                                 x, y, c, diff, bout, ovf, ed, eb, eo);
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_basic;
        test_ignore_start;
        test_async_reset;
        test_back_to_back;
        test_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
